// File: rtl/gcd_pkg.sv
// Shared types for the GCD controller and its subtract/swap datapath.
package gcd_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_SWAP = 2'd2,
    OP_SUB  = 2'd3
  } gcd_op_e;

endpackage

// File: rtl/gcd_dpath.sv
// Operand registers with swap/subtract step and the comparators the controller steers on.
module gcd_dpath
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  gcd_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  input  logic                  i_load_a,
  input  logic                  i_load_b,
  output logic                  o_a_lt_b,
  output logic                  o_b_zero,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      case (i_op)
        OP_LOAD: begin
          // Each operand loads only on its own transfer; both may land together.
          if (i_load_a) r_a <= i_a_data;
          if (i_load_b) r_b <= i_b_data;
        end
        OP_SWAP: begin
          r_a <= r_b;
          r_b <= r_a;
        end
        OP_SUB:  r_a <= r_a - r_b;
        default: ;
      endcase
    end
  end

  assign o_a_lt_b = (r_a < r_b);
  assign o_b_zero = (r_b == '0);
  assign o_result = r_a;

endmodule

// File: rtl/gcd_ctrl.sv
// GCD controller: collects A and B in any order, iterates the datapath, holds Y until taken.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_en,
  output logic                  a_rdy,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_en,
  output logic                  b_rdy,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  y_en,
  output logic                  y_rdy,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cyc_cnt
);

  gcd_state_e            r_state;
  logic                  r_a_got;
  logic                  r_b_got;
  logic [DATA_WIDTH-1:0] r_y_data;
  logic [CNT_WIDTH-1:0]  r_cyc_cnt;

  logic                  w_a_xfer;
  logic                  w_b_xfer;
  logic                  w_a_lt_b;
  logic                  w_b_zero;
  logic [DATA_WIDTH-1:0] w_result;
  gcd_op_e               w_op;

  assign a_rdy    = (r_state == IDLE) && !r_a_got && !rst_i;
  assign b_rdy    = (r_state == IDLE) && !r_b_got && !rst_i;
  assign y_rdy    = (r_state == DONE);
  assign busy     = (r_state == CALC);
  assign y_data   = r_y_data;
  assign cyc_cnt  = r_cyc_cnt;
  assign w_a_xfer = a_en && a_rdy;
  assign w_b_xfer = b_en && b_rdy;

  always_comb begin
    w_op = OP_HOLD;
    if (r_state == IDLE && (w_a_xfer || w_b_xfer)) begin
      w_op = OP_LOAD;
    end else if (r_state == CALC) begin
      if (w_a_lt_b)       w_op = OP_SWAP;
      else if (!w_b_zero) w_op = OP_SUB;
    end
  end

  gcd_dpath #(.DATA_WIDTH(DATA_WIDTH)) u_dpath (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_op     (w_op),
    .i_a_data (a_data),
    .i_b_data (b_data),
    .i_load_a (w_a_xfer),
    .i_load_b (w_b_xfer),
    .o_a_lt_b (w_a_lt_b),
    .o_b_zero (w_b_zero),
    .o_result (w_result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_a_got   <= 1'b0;
      r_b_got   <= 1'b0;
      r_y_data  <= '0;
      r_cyc_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_a_xfer) r_a_got <= 1'b1;
          if (w_b_xfer) r_b_got <= 1'b1;
          if (r_a_got && r_b_got) begin
            r_state   <= CALC;
            r_cyc_cnt <= '0;
          end
        end
        CALC: begin
          // The terminating step counts too; saturate rather than wrap.
          if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + CNT_WIDTH'(1);
          if (!w_a_lt_b && w_b_zero) begin
            r_y_data <= w_result;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (y_en) begin
            r_state <= IDLE;
            r_a_got <= 1'b0;
            r_b_got <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed-vector and corner-sequence bench for gcd_ctrl.
module tb_gcd_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int TIMEOUT = 600;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          a_en = 1'b0, b_en = 1'b0, y_en = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_rdy, b_rdy, y_rdy, busy;
  logic [DW-1:0] y_data;
  logic [CW-1:0] cyc_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int a;
    int b;
    int exp_y;
    int exp_cnt;
  } vec_t;

  vec_t vecs[8];

  gcd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_en    (a_en),
    .a_rdy   (a_rdy),
    .a_data  (a_data),
    .b_en    (b_en),
    .b_rdy   (b_rdy),
    .b_data  (b_data),
    .y_en    (y_en),
    .y_rdy   (y_rdy),
    .y_data  (y_data),
    .busy    (busy),
    .cyc_cnt (cyc_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic send_both(input int a, input int b);
    @(negedge clk_i);
    chk("a_rdy_before_send", int'(a_rdy), 1);
    chk("b_rdy_before_send", int'(b_rdy), 1);
    a_en = 1'b1; a_data = DW'(a);
    b_en = 1'b1; b_data = DW'(b);
    @(negedge clk_i);
    a_en = 1'b0; b_en = 1'b0;
  endtask

  task automatic wait_y(input string name);
    int n = 0;
    while (!y_rdy && n < TIMEOUT) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_timeout"}, int'(y_rdy), 1);
  endtask

  task automatic take_y(input string name);
    y_en = 1'b1;
    @(negedge clk_i);
    y_en = 1'b0;
    chk({name, "_y_rdy_after_take"}, int'(y_rdy), 0);
    chk({name, "_a_rdy_after_take"}, int'(a_rdy), 1);
    chk({name, "_b_rdy_after_take"}, int'(b_rdy), 1);
  endtask

  initial begin
    vecs[0] = '{12, 5, 1, 10};
    vecs[1] = '{0, 7, 7, 2};
    vecs[2] = '{9, 0, 9, 1};
    vecs[3] = '{0, 0, 0, 1};
    vecs[4] = '{8, 12, 4, 7};
    vecs[5] = '{24, 18, 6, 7};
    vecs[6] = '{7, 7, 7, 3};
    vecs[7] = '{255, 1, 1, 255};

    // Reset state, reset held for a few cycles
    repeat (3) @(negedge clk_i);
    chk("rst_a_rdy", int'(a_rdy), 0);
    chk("rst_b_rdy", int'(b_rdy), 0);
    chk("rst_y_rdy", int'(y_rdy), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_y_data", int'(y_data), 0);
    chk("rst_cyc_cnt", int'(cyc_cnt), 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_a_rdy", int'(a_rdy), 1);
    chk("post_rst_b_rdy", int'(b_rdy), 1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      send_both(vecs[i].a, vecs[i].b);
      wait_y($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_y", i), int'(y_data), vecs[i].exp_y);
      chk($sformatf("vec%0d_cnt", i), int'(cyc_cnt), vecs[i].exp_cnt);
      $display("vec %0d: a=%0d b=%0d -> y=%0d cnt=%0d", i, vecs[i].a, vecs[i].b, y_data, cyc_cnt);
      take_y($sformatf("vec%0d", i));
    end

    // Basic: y_en held high, y_rdy must pulse exactly one cycle
    y_en = 1'b1;
    send_both(12, 5);
    begin
      int n = 0;
      while (!y_rdy && n < TIMEOUT) begin @(negedge clk_i); n++; end
    end
    chk("basic_y_rdy", int'(y_rdy), 1);
    chk("basic_y", int'(y_data), 1);
    chk("basic_cnt", int'(cyc_cnt), 10);
    @(negedge clk_i);
    y_en = 1'b0;
    chk("basic_pulse", int'(y_rdy), 0);
    chk("basic_a_rdy", int'(a_rdy), 1);
    chk("basic_b_rdy", int'(b_rdy), 1);
    $display("basic: 12,5 -> y=%0d", y_data);

    // Order and back-pressure: B first, A three cycles later
    @(negedge clk_i);
    b_en = 1'b1; b_data = 8'd18;
    @(negedge clk_i);
    b_en = 1'b0;
    chk("order_b_rdy_low", int'(b_rdy), 0);
    chk("order_a_rdy_high", int'(a_rdy), 1);
    repeat (3) @(negedge clk_i);
    chk("order_still_idle", int'(busy), 0);
    a_en = 1'b1; a_data = 8'd24;
    @(negedge clk_i);
    a_en = 1'b0;
    wait_y("order");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("order_hold_rdy%0d", k), int'(y_rdy), 1);
      chk($sformatf("order_hold_y%0d", k), int'(y_data), 6);
      @(negedge clk_i);
    end
    $display("order: b=18 then a=24 -> y=%0d held 5 cycles", y_data);
    take_y("order");

    // Ignored strobes: repeated A while waiting for B, strobes during CALC
    @(negedge clk_i);
    a_en = 1'b1; a_data = 8'd12;
    @(negedge clk_i);
    a_data = 8'd3;
    chk("ign_a_rdy_low", int'(a_rdy), 0);
    @(negedge clk_i);
    a_en = 1'b0;
    b_en = 1'b1; b_data = 8'd5;
    @(negedge clk_i);
    b_en = 1'b0;
    begin
      int n = 0;
      while (!busy && n < TIMEOUT) begin @(negedge clk_i); n++; end
    end
    chk("ign_busy", int'(busy), 1);
    a_en = 1'b1; b_en = 1'b1; a_data = 8'd3; b_data = 8'd3;
    repeat (2) @(negedge clk_i);
    a_en = 1'b0; b_en = 1'b0;
    wait_y("ign");
    chk("ign_y", int'(y_data), 1);
    chk("ign_cnt", int'(cyc_cnt), 10);
    $display("ignored strobes: 12,5 -> y=%0d cnt=%0d", y_data, cyc_cnt);
    take_y("ign");

    // Reset asserted off-edge in the 4th CALC cycle
    send_both(255, 1);
    begin
      int n = 0;
      while (!busy && n < TIMEOUT) begin @(negedge clk_i); n++; end
    end
    chk("mid_busy", int'(busy), 1);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_a_rdy", int'(a_rdy), 0);
    chk("mid_rst_b_rdy", int'(b_rdy), 0);
    chk("mid_rst_y_rdy", int'(y_rdy), 0);
    chk("mid_rst_cnt", int'(cyc_cnt), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    send_both(8, 12);
    wait_y("after_rst");
    chk("after_rst_y", int'(y_data), 4);
    $display("after reset: 8,12 -> y=%0d", y_data);
    take_y("after_rst");

    // Random pairs against a modulo-based reference
    for (int r = 0; r < 200; r++) begin
      int ra, rb;
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      send_both(ra, rb);
      wait_y($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_y", r), int'(y_data), gcd_ref(ra, rb));
      checks++;
      if (cyc_cnt == '0) begin
        errors++;
        $display("FAIL rnd%0d_cnt_nonzero: got 0 expected nonzero", r);
      end
      $display("rnd %0d: a=%0d b=%0d -> y=%0d cnt=%0d", r, ra, rb, y_data, cyc_cnt);
      take_y($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
